// File: rtl/csr_exc_commit.sv
// Exception/interrupt/timer CSR file with writeback-stage commit.
// Takes exception entry and ERTN return, and raises the timer/software interrupt lines.
module csr_exc_commit #(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          TIMER_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [13:0]        csr_num,
    input  logic               csr_re,
    input  logic               csr_we,
    input  logic [31:0]        csr_wmask,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rvalue,
    input  logic               ws_ex,
    input  logic [5:0]         ws_ecode,
    input  logic               ws_esubcode,
    input  logic [31:0]        ws_pc,
    input  logic [31:0]        ws_vaddr,
    input  logic               ertn_flush,
    input  logic [7:0]         hw_int_in,
    input  logic               ipi_int_in,
    output logic [31:0]        ex_entry,
    output logic [31:0]        ertn_pc,
    output logic               has_int,
    output logic               ti_out,
    output logic [1:0]         swi_out
);

    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;

    logic [1:0]         crmd_plv;
    logic               crmd_ie;
    logic               crmd_da;
    logic               crmd_pg;
    logic [1:0]         prmd_pplv;
    logic               prmd_pie;
    logic [12:0]        ecfg_lie;
    logic [12:0]        estat_is;
    logic [5:0]         estat_ecode;
    logic               estat_esub;
    logic [31:0]        era;
    logic [31:0]        badv;
    logic [25:0]        eentry;
    logic [31:0]        save0;
    logic [31:0]        save1;
    logic [31:0]        save2;
    logic [31:0]        save3;
    logic [31:0]        tid;
    logic [31:0]        tcfg;
    logic [TIMER_W-1:0] tval;

    logic [31:0]        merged;
    logic               wr_en;
    logic               we_tcfg;
    logic               we_estat;
    logic               ticlr_clr;
    logic               ti_set;
    logic [TIMER_W-1:0] tval_nx;
    logic [12:0]        is_nx;
    logic               badv_pc;
    logic               badv_va;
    logic               unused_sig;

    assign unused_sig = csr_re;

    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            A_CRMD:   csr_rvalue = {27'h0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
            A_PRMD:   csr_rvalue = {29'h0, prmd_pie, prmd_pplv};
            A_ECFG:   csr_rvalue = {19'h0, ecfg_lie};
            A_ESTAT:  csr_rvalue = {9'h0, estat_esub, estat_ecode, 3'h0, estat_is};
            A_ERA:    csr_rvalue = era;
            A_BADV:   csr_rvalue = badv;
            A_EENTRY: csr_rvalue = {eentry, 6'h0};
            A_SAVE0:  csr_rvalue = save0;
            A_SAVE1:  csr_rvalue = save1;
            A_SAVE2:  csr_rvalue = save2;
            A_SAVE3:  csr_rvalue = save3;
            A_TID:    csr_rvalue = tid;
            A_TCFG:   csr_rvalue = tcfg;
            A_TVAL:   csr_rvalue = tval;
            default:  csr_rvalue = 32'h0;
        endcase
    end

    // Masked merge against the addressed CSR's current read value
    assign merged    = (csr_rvalue & ~csr_wmask) | (csr_wdata & csr_wmask);
    assign wr_en     = csr_we & ~ws_ex & ~ertn_flush;
    assign we_tcfg   = wr_en & (csr_num == A_TCFG);
    assign we_estat  = wr_en & (csr_num == A_ESTAT);
    assign ticlr_clr = wr_en & (csr_num == A_TICLR) & merged[0];

    always_comb begin
        tval_nx = tval;
        ti_set  = 1'b0;
        if (we_tcfg) begin
            if (merged[0])
                tval_nx = {merged[31:2], 2'b00};
        end else if (tcfg[0] && tval != '0) begin
            if (tval == TIMER_W'(1)) begin
                ti_set  = 1'b1;
                tval_nx = tcfg[1] ? {tcfg[31:2], 2'b00} : '0;
            end else begin
                tval_nx = tval - TIMER_W'(1);
            end
        end
    end

    always_comb begin
        is_nx       = estat_is;
        is_nx[1:0]  = we_estat ? merged[1:0] : estat_is[1:0];
        is_nx[9:2]  = hw_int_in;
        is_nx[10]   = 1'b0;
        is_nx[11]   = ti_set | (estat_is[11] & ~ticlr_clr);
        is_nx[12]   = ipi_int_in;
    end

    assign badv_pc = (ws_ecode == 6'h08) & ~ws_esubcode;
    assign badv_va = ((ws_ecode == 6'h08) & ws_esubcode)
                   | (ws_ecode == 6'h09)
                   | ((ws_ecode >= 6'h01) & (ws_ecode <= 6'h07))
                   | (ws_ecode == 6'h3F);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crmd_plv    <= 2'b00;
            crmd_ie     <= 1'b0;
            crmd_da     <= 1'b1;
            crmd_pg     <= 1'b0;
            prmd_pplv   <= 2'b00;
            prmd_pie    <= 1'b0;
            ecfg_lie    <= 13'h0;
            estat_is    <= 13'h0;
            estat_ecode <= 6'h0;
            estat_esub  <= 1'b0;
            era         <= 32'h0;
            badv        <= 32'h0;
            eentry      <= 26'h0;
            save0       <= 32'h0;
            save1       <= 32'h0;
            save2       <= 32'h0;
            save3       <= 32'h0;
            tid         <= TID_RESET;
            tcfg        <= 32'h0;
            tval        <= '1;
        end else begin
            estat_is <= is_nx;
            tval     <= tval_nx;
            if (ws_ex) begin
                prmd_pplv   <= crmd_plv;
                prmd_pie    <= crmd_ie;
                crmd_plv    <= 2'b00;
                crmd_ie     <= 1'b0;
                era         <= ws_pc;
                estat_ecode <= ws_ecode;
                estat_esub  <= ws_esubcode;
                if (badv_pc)
                    badv <= ws_pc;
                else if (badv_va)
                    badv <= ws_vaddr;
            end else if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end else if (wr_en) begin
                unique case (1'b1)
                    csr_num == A_CRMD: begin
                        crmd_plv <= merged[1:0];
                        crmd_ie  <= merged[2];
                        crmd_da  <= merged[3];
                        crmd_pg  <= merged[4];
                    end
                    csr_num == A_PRMD: begin
                        prmd_pplv <= merged[1:0];
                        prmd_pie  <= merged[2];
                    end
                    csr_num == A_ECFG:   ecfg_lie <= {merged[12:11], 1'b0, merged[9:0]};
                    csr_num == A_ERA:    era      <= merged;
                    csr_num == A_BADV:   badv     <= merged;
                    csr_num == A_EENTRY: eentry   <= merged[31:6];
                    csr_num == A_SAVE0:  save0    <= merged;
                    csr_num == A_SAVE1:  save1    <= merged;
                    csr_num == A_SAVE2:  save2    <= merged;
                    csr_num == A_SAVE3:  save3    <= merged;
                    csr_num == A_TID:    tid      <= merged;
                    csr_num == A_TCFG:   tcfg     <= merged;
                    default: ;
                endcase
            end
        end
    end

    assign ex_entry = {eentry, 6'h0};
    assign ertn_pc  = era;
    assign has_int  = crmd_ie & |(estat_is & ecfg_lie);
    assign ti_out   = estat_is[11];
    assign swi_out  = estat_is[1:0];

endmodule

// File: tb/tb_csr_exc_commit.sv
// Directed bench for csr_exc_commit.
// Hand-computed expectations for CSR access, exception commit, interrupts and timer.
`timescale 1ns/1ps
module tb_csr_exc_commit;

    logic        clk;
    logic        rst;
    logic [13:0] csr_num;
    logic        csr_re;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rvalue;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic        ws_esubcode;
    logic [31:0] ws_pc;
    logic [31:0] ws_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;
    logic        ti_out;
    logic [1:0]  swi_out;

    int total = 0;
    int bad   = 0;

    csr_exc_commit #(.TID_RESET(32'h0), .TIMER_W(32)) dut (
        .clk(clk), .rst(rst),
        .csr_num(csr_num), .csr_re(csr_re), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rvalue(csr_rvalue),
        .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
        .ws_pc(ws_pc), .ws_vaddr(ws_vaddr), .ertn_flush(ertn_flush),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_pc(ertn_pc), .has_int(has_int),
        .ti_out(ti_out), .swi_out(swi_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [13:0] num, output logic [31:0] v);
        csr_num = num;
        #1;
        v = csr_rvalue;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] d, input logic [31:0] m);
        csr_num = num;
        csr_wdata = d;
        csr_wmask = m;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic exc(input logic [5:0] ec, input logic sub,
                       input logic [31:0] pc, input logic [31:0] va);
        ws_ex = 1'b1;
        ws_ecode = ec;
        ws_esubcode = sub;
        ws_pc = pc;
        ws_vaddr = va;
        tick();
        ws_ex = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b0;
        csr_num = '0; csr_re = 1'b0; csr_we = 1'b0;
        csr_wmask = '0; csr_wdata = '0;
        ws_ex = 1'b0; ws_ecode = '0; ws_esubcode = 1'b0;
        ws_pc = '0; ws_vaddr = '0; ertn_flush = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;
        tick(3);
        rst = 1'b1;
        tick();

        rd(14'h00, v); chk("rst_crmd", v, 32'h8);
        rd(14'h05, v); chk("rst_estat", v, 32'h0);
        rd(14'h42, v); chk("rst_tval", v, 32'hFFFF_FFFF);
        chk("rst_entry", ex_entry, 32'h0);
        chk("rst_hasint", {31'h0, has_int}, 32'h0);

        wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h05, v); chk("estat_ro", v, 32'h3);
        chk("swi", {30'h0, swi_out}, 32'h3);
        wr(14'h05, 32'h0, 32'hFFFF_FFFF);
        wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h04, v); chk("ecfg_b10", v, 32'h1BFF);
        wr(14'h04, 32'h0, 32'hFFFF_FFFF);

        wr(14'h0C, 32'h1C00_8044, 32'hFFFF_FFFF);
        wr(14'h00, 32'h7, 32'h7);
        rd(14'h00, v); chk("crmd_wr", v, 32'hF);
        exc(6'h0B, 1'b0, 32'h1C00_0100, 32'h1234);
        rd(14'h06, v); chk("era", v, 32'h1C00_0100);
        rd(14'h05, v); chk("estat_ec", v, 32'h000B_0000);
        rd(14'h01, v); chk("prmd", v, 32'h7);
        rd(14'h00, v); chk("crmd_ex", v, 32'h8);
        rd(14'h07, v); chk("badv_keep", v, 32'h0);
        chk("ex_entry", ex_entry, 32'h1C00_8040);
        chk("ertn_pc", ertn_pc, 32'h1C00_0100);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd(14'h00, v); chk("crmd_ertn", v, 32'hF);

        wr(14'h30, 32'h1234_5678, 32'hFFFF_FFFF);
        csr_num = 14'h30; csr_wdata = 32'hDEAD_BEEF;
        csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
        exc(6'h09, 1'b0, 32'h1C00_0180, 32'hA000_0003);
        csr_we = 1'b0;
        rd(14'h07, v); chk("badv_09", v, 32'hA000_0003);
        rd(14'h30, v); chk("save0_blk", v, 32'h1234_5678);
        exc(6'h08, 1'b0, 32'h1C00_0200, 32'h55);
        rd(14'h07, v); chk("badv_08s0", v, 32'h1C00_0200);
        rd(14'h05, v); chk("estat_08", v, 32'h0008_0000);
        exc(6'h08, 1'b1, 32'h1C00_0204, 32'hB000_0000);
        rd(14'h07, v); chk("badv_08s1", v, 32'hB000_0000);
        rd(14'h05, v); chk("estat_sub", v, 32'h0048_0000);
        exc(6'h3F, 1'b0, 32'h1C00_0208, 32'h77);
        rd(14'h07, v); chk("badv_3f", v, 32'h77);
        exc(6'h0D, 1'b0, 32'h1C00_020C, 32'h99);
        rd(14'h07, v); chk("badv_0d", v, 32'h77);

        wr(14'h04, 32'h4, 32'hFFFF_FFFF);
        wr(14'h00, 32'h4, 32'h4);
        hw_int_in = 8'h01;
        tick();
        rd(14'h05, v); chk("is2", v & 32'h1FFF, 32'h4);
        chk("hasint_on", {31'h0, has_int}, 32'h1);
        hw_int_in = 8'h00;
        tick();
        chk("hasint_off", {31'h0, has_int}, 32'h0);
        wr(14'h04, 32'h1000, 32'hFFFF_FFFF);
        ipi_int_in = 1'b1;
        tick();
        chk("hasint_ipi", {31'h0, has_int}, 32'h1);
        ipi_int_in = 1'b0;
        tick();
        chk("hasint_ipi0", {31'h0, has_int}, 32'h0);

        wr(14'h41, 32'h13, 32'hFFFF_FFFF);
        rd(14'h42, v); chk("tval_load", v, 32'd16);
        tick();
        rd(14'h42, v); chk("tval_dec", v, 32'd15);
        tick(14);
        rd(14'h42, v); chk("tval_one", v, 32'd1);
        chk("ti_before", {31'h0, ti_out}, 32'h0);
        tick();
        chk("ti_fire", {31'h0, ti_out}, 32'h1);
        rd(14'h42, v); chk("tval_reload", v, 32'd16);
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        chk("ticlr", {31'h0, ti_out}, 32'h0);
        rd(14'h42, v); chk("tval_run", v, 32'd15);
        wr(14'h41, 32'h12, 32'hFFFF_FFFF);
        tick(3);
        rd(14'h42, v); chk("tval_frozen", v, 32'd15);

        wr(14'h41, 32'h5, 32'hFFFF_FFFF);
        tick(3);
        rd(14'h42, v); chk("np_one", v, 32'd1);
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        chk("ti_wins", {31'h0, ti_out}, 32'h1);
        tick(2);
        rd(14'h42, v); chk("np_hold", v, 32'd0);
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        chk("ticlr2", {31'h0, ti_out}, 32'h0);
        wr(14'h41, 32'h1, 32'hFFFF_FFFF);
        tick(3);
        rd(14'h42, v); chk("init0_tval", v, 32'd0);
        chk("init0_ti", {31'h0, ti_out}, 32'h0);

        wr(14'h41, 32'h13, 32'hFFFF_FFFF);
        tick(3);
        csr_num = 14'h42;
        rst = 1'b0;
        #1;
        chk("arst_tval", csr_rvalue, 32'hFFFF_FFFF);
        rd(14'h00, v); chk("arst_crmd", v, 32'h8);
        rst = 1'b1;
        tick(2);
        rd(14'h42, v); chk("arst_stop", v, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
